// File: rtl/udp_oe_pkg.sv
// Shared types and constants for the UDP offload-engine CSR block: config struct,
// word map, channel offsets, DFH identity words and the bad-address read value.
package udp_oe_pkg;

   typedef struct packed {
      logic [15:0] fpga_udp_port;
      logic [15:0] host_udp_port;
      logic [47:0] fpga_mac;
      logic [47:0] host_mac;
      logic [31:0] fpga_ip;
      logic [31:0] host_ip;
      logic [31:0] netmask;
      logic [15:0] payload_per_packet;
      logic [15:0] checksum_ip;
   } udp_oe_cfg_t;

   typedef enum logic [1:0] {
      RST_IDLE  = 2'd0,
      RST_HELD  = 2'd1,
      RST_PULSE = 2'd2
   } rst_state_t;

   // Common register words (byte address >> 3)
   localparam logic [8:0] W_DFH_HDR         = 9'h000;
   localparam logic [8:0] W_ID_LO           = 9'h001;
   localparam logic [8:0] W_ID_HI           = 9'h002;
   localparam logic [8:0] W_REG_OFFSET      = 9'h003;
   localparam logic [8:0] W_REG_PARAMS      = 9'h004;
   localparam logic [8:0] W_SCRATCH         = 9'h005;
   localparam logic [8:0] W_NUM_CHAN        = 9'h006;
   localparam logic [8:0] W_FPGA_UDP_PORT   = 9'h007;
   localparam logic [8:0] W_HOST_UDP_PORT   = 9'h008;
   localparam logic [8:0] W_FPGA_MAC        = 9'h009;
   localparam logic [8:0] W_HOST_MAC        = 9'h00A;
   localparam logic [8:0] W_FPGA_IP         = 9'h00B;
   localparam logic [8:0] W_HOST_IP         = 9'h00C;
   localparam logic [8:0] W_NETMASK         = 9'h00D;
   localparam logic [8:0] W_PAYLOAD         = 9'h00E;
   localparam logic [8:0] W_CHECKSUM_IP     = 9'h00F;

   localparam logic [3:0] CH_INFO     = 4'h0;
   localparam logic [3:0] CH_RST_CTRL = 4'h1;
   localparam logic [3:0] CH_STATUS   = 4'h2;
   localparam logic [3:0] CH_MISC     = 4'h3;
   localparam logic [3:0] CH_TX_CNT   = 4'h4;
   localparam logic [3:0] CH_RX_CNT   = 4'h5;

   localparam logic [63:0] DFH_HEADER     = 64'h3000_0001_0000_1001;
   localparam logic [63:0] DFH_ID_LO      = 64'hB9F1_4E2A_5C7D_0011;
   localparam logic [63:0] DFH_ID_HI      = 64'h4F3E_9A1C_77D2_8E45;
   localparam logic [63:0] DFH_REG_OFFSET = 64'h0000_0000_0000_0000;
   localparam logic [63:0] DFH_REG_PARAMS = 64'h0000_0000_0000_0040;

   localparam logic [63:0] REG_RD_BADADDR_DATA = 64'hBAAD_ADD0_BAAD_ADD0;

   function automatic logic [63:0] be_merge(input logic [63:0] old_v,
                                            input logic [63:0] new_v,
                                            input logic [7:0]  be);
      logic [63:0] r;
      r = old_v;
      for (int i = 0; i < 8; i++) begin
         if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/udp_oe_csr_multich_if.sv
// Avalon-MM CSR bus bundle for udp_oe_csr_multich (64-bit data, 12-bit byte address).
interface udp_oe_csr_multich_if;

   // Handshake: read/write are accepted in every cycle they are high (waitrequest
   // is tied low); each read is answered by readdatavalid exactly one cycle later.
   logic [11:0] avmm_address;
   logic        avmm_read;
   logic        avmm_write;
   logic [63:0] avmm_writedata;
   logic [7:0]  avmm_byteenable;
   logic [63:0] avmm_readdata;
   logic        avmm_readdatavalid;
   logic        avmm_waitrequest;

   modport master (
      output avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable,
      input  avmm_readdata, avmm_readdatavalid, avmm_waitrequest
   );

   modport slave (
      input  avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable,
      output avmm_readdata, avmm_readdatavalid, avmm_waitrequest
   );

endinterface

// File: rtl/udp_oe_csr_chan.sv
// One channel: tx/rx reset FSM (IDLE/HELD/PULSE) and packet counters.
// Counters exist only when UDP_OE_CSR_PKT_CNT_EN is defined.
module udp_oe_csr_chan
   import udp_oe_pkg::*;
#(
   parameter int RST_PULSE_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rst_wr_i,
   input  logic        rst_auto_i,
   input  logic        rst_tx_i,
   input  logic        rst_rx_i,
   input  logic        tx_cnt_clr_i,
   input  logic        rx_cnt_clr_i,
   input  logic        tx_pkt_i,
   input  logic        rx_pkt_i,
   output logic        tx_rst_o,
   output logic        rx_rst_o,
   output rst_state_t  state_o,
   output logic [31:0] tx_cnt_o,
   output logic [31:0] rx_cnt_o
);

   rst_state_t state_q;
   logic [7:0] pulse_cnt_q;
   logic       tx_rst_q;
   logic       rx_rst_q;

   // Pulse lasts while pulse_cnt_q counts N..1; leaving on 1 gives exactly N cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RST_IDLE;
         pulse_cnt_q <= 8'd0;
         tx_rst_q    <= 1'b0;
         rx_rst_q    <= 1'b0;
      end else if (rst_wr_i) begin
         tx_rst_q <= rst_tx_i;
         rx_rst_q <= rst_rx_i;
         if (!(rst_tx_i || rst_rx_i)) begin
            state_q     <= RST_IDLE;
            pulse_cnt_q <= 8'd0;
         end else if (rst_auto_i) begin
            state_q     <= RST_PULSE;
            pulse_cnt_q <= 8'(RST_PULSE_CYCLES);
         end else begin
            state_q     <= RST_HELD;
            pulse_cnt_q <= 8'd0;
         end
      end else if (state_q == RST_PULSE) begin
         if (pulse_cnt_q == 8'd1) begin
            state_q     <= RST_IDLE;
            pulse_cnt_q <= 8'd0;
            tx_rst_q    <= 1'b0;
            rx_rst_q    <= 1'b0;
         end else begin
            pulse_cnt_q <= pulse_cnt_q - 8'd1;
         end
      end
   end

   assign tx_rst_o = tx_rst_q;
   assign rx_rst_o = rx_rst_q;
   assign state_o  = state_q;

`ifdef UDP_OE_CSR_PKT_CNT_EN
   logic [31:0] tx_cnt_q;
   logic [31:0] rx_cnt_q;

   // A clear coinciding with a packet leaves the count at 1, not 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_cnt_q <= 32'd0;
         rx_cnt_q <= 32'd0;
      end else begin
         if (tx_cnt_clr_i)                       tx_cnt_q <= {31'd0, tx_pkt_i};
         else if (tx_pkt_i && (tx_cnt_q != '1))  tx_cnt_q <= tx_cnt_q + 32'd1;
         if (rx_cnt_clr_i)                       rx_cnt_q <= {31'd0, rx_pkt_i};
         else if (rx_pkt_i && (rx_cnt_q != '1))  rx_cnt_q <= rx_cnt_q + 32'd1;
      end
   end

   assign tx_cnt_o = tx_cnt_q;
   assign rx_cnt_o = rx_cnt_q;
`else
   logic unused_cnt_in;
   assign unused_cnt_in = ^{tx_cnt_clr_i, rx_cnt_clr_i, tx_pkt_i, rx_pkt_i};
   assign tx_cnt_o = 32'd0;
   assign rx_cnt_o = 32'd0;
`endif

endmodule

// File: rtl/udp_oe_csr_multich.sv
// Avalon-MM CSR block for the UDP offload engine: common config plus NUM_CHAN channel
// blocks. Define UDP_OE_CSR_PKT_CNT_EN to include the per-channel packet counters.
module udp_oe_csr_multich
   import udp_oe_pkg::*;
#(
   parameter int NUM_CHAN         = 2,
   parameter int CHAN_BASE        = 'h20,
   parameter int RST_PULSE_CYCLES = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   udp_oe_csr_multich_if.slave          avmm,
   output udp_oe_cfg_t                  cfg,
   output logic [NUM_CHAN-1:0]          chan_tx_rst,
   output logic [NUM_CHAN-1:0]          chan_rx_rst,
   output logic [NUM_CHAN-1:0][63:0]    chan_misc_ctrl,
   input  logic [NUM_CHAN-1:0][31:0]    chan_tx_status,
   input  logic [NUM_CHAN-1:0][31:0]    chan_rx_status,
   input  logic [NUM_CHAN-1:0]          chan_tx_pkt,
   input  logic [NUM_CHAN-1:0]          chan_rx_pkt
);

   logic [8:0]  word;
   logic [2:0]  unused_addr_lsb;
   logic [9:0]  chan_off;
   logic        in_chan;
   logic [5:0]  chan_idx;
   logic [3:0]  ch_sub;
   logic [63:0] wd;
   logic [7:0]  be;

   assign word            = avmm.avmm_address[11:3];
   assign unused_addr_lsb = avmm.avmm_address[2:0];
   assign wd              = avmm.avmm_writedata;
   assign be              = avmm.avmm_byteenable;
   assign in_chan         = ({1'b0, word} >= 10'(CHAN_BASE));
   assign chan_off        = {1'b0, word} - 10'(CHAN_BASE);
   assign chan_idx        = chan_off[9:4];
   assign ch_sub          = chan_off[3:0];

   logic [NUM_CHAN-1:0]       ch_sel;
   logic [NUM_CHAN-1:0]       rst_wr;
   logic [NUM_CHAN-1:0]       tx_clr;
   logic [NUM_CHAN-1:0]       rx_clr;
   logic [NUM_CHAN-1:0][31:0] tx_cnt;
   logic [NUM_CHAN-1:0][31:0] rx_cnt;
   rst_state_t                ch_state [NUM_CHAN];
   logic [63:0]               ch_rd    [NUM_CHAN];

   logic [63:0]               scratch_q, scratch_d;
   udp_oe_cfg_t               cfg_q, cfg_d;
   logic [NUM_CHAN-1:0][63:0] misc_q, misc_d;
   logic [63:0]               rd_data;
   logic [63:0]               readdata_q;
   logic                      rdvalid_q;

   for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
      assign ch_sel[c] = in_chan && (chan_idx == 6'(c));
      // Reset control lives entirely in byte lane 0.
      assign rst_wr[c] = avmm.avmm_write && ch_sel[c] && (ch_sub == CH_RST_CTRL) && be[0];
      assign tx_clr[c] = avmm.avmm_write && ch_sel[c] && (ch_sub == CH_TX_CNT);
      assign rx_clr[c] = avmm.avmm_write && ch_sel[c] && (ch_sub == CH_RX_CNT);

      udp_oe_csr_chan #(
         .RST_PULSE_CYCLES (RST_PULSE_CYCLES)
      ) u_chan (
         .clk          (clk),
         .reset        (reset),
         .rst_wr_i     (rst_wr[c]),
         .rst_auto_i   (wd[4]),
         .rst_tx_i     (wd[1]),
         .rst_rx_i     (wd[0]),
         .tx_cnt_clr_i (tx_clr[c]),
         .rx_cnt_clr_i (rx_clr[c]),
         .tx_pkt_i     (chan_tx_pkt[c]),
         .rx_pkt_i     (chan_rx_pkt[c]),
         .tx_rst_o     (chan_tx_rst[c]),
         .rx_rst_o     (chan_rx_rst[c]),
         .state_o      (ch_state[c]),
         .tx_cnt_o     (tx_cnt[c]),
         .rx_cnt_o     (rx_cnt[c])
      );

      assign ch_rd[c] =
         (ch_sub == CH_INFO)     ? {47'd0, 1'(c == NUM_CHAN - 1), 8'(c), 8'h10} :
         (ch_sub == CH_RST_CTRL) ? {59'd0, (ch_state[c] == RST_PULSE), 2'b00,
                                    chan_tx_rst[c], chan_rx_rst[c]} :
         (ch_sub == CH_STATUS)   ? {chan_tx_status[c], chan_rx_status[c]} :
         (ch_sub == CH_MISC)     ? misc_q[c] :
         (ch_sub == CH_TX_CNT)   ? {32'd0, tx_cnt[c]} :
         (ch_sub == CH_RX_CNT)   ? {32'd0, rx_cnt[c]} :
                                   REG_RD_BADADDR_DATA;
   end

   always_comb begin
      rd_data = REG_RD_BADADDR_DATA;
      if (!in_chan) begin
         case (word)
            W_DFH_HDR:       rd_data = DFH_HEADER;
            W_ID_LO:         rd_data = DFH_ID_LO;
            W_ID_HI:         rd_data = DFH_ID_HI;
            W_REG_OFFSET:    rd_data = DFH_REG_OFFSET;
            W_REG_PARAMS:    rd_data = DFH_REG_PARAMS;
            W_SCRATCH:       rd_data = scratch_q;
            W_NUM_CHAN:      rd_data = 64'(NUM_CHAN);
            W_FPGA_UDP_PORT: rd_data = 64'(cfg_q.fpga_udp_port);
            W_HOST_UDP_PORT: rd_data = 64'(cfg_q.host_udp_port);
            W_FPGA_MAC:      rd_data = 64'(cfg_q.fpga_mac);
            W_HOST_MAC:      rd_data = 64'(cfg_q.host_mac);
            W_FPGA_IP:       rd_data = 64'(cfg_q.fpga_ip);
            W_HOST_IP:       rd_data = 64'(cfg_q.host_ip);
            W_NETMASK:       rd_data = 64'(cfg_q.netmask);
            W_PAYLOAD:       rd_data = 64'(cfg_q.payload_per_packet);
            W_CHECKSUM_IP:   rd_data = 64'(cfg_q.checksum_ip);
            default:         rd_data = REG_RD_BADADDR_DATA;
         endcase
      end else begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            if (ch_sel[c]) rd_data = ch_rd[c];
         end
      end
   end

   // Narrow cfg fields merge against their zero-extended value, then truncate.
   always_comb begin
      scratch_d = scratch_q;
      cfg_d     = cfg_q;
      misc_d    = misc_q;
      if (avmm.avmm_write && !in_chan) begin
         case (word)
            W_SCRATCH:       scratch_d = be_merge(scratch_q, wd, be);
            W_FPGA_UDP_PORT: cfg_d.fpga_udp_port = 16'(be_merge(64'(cfg_q.fpga_udp_port), wd, be));
            W_HOST_UDP_PORT: cfg_d.host_udp_port = 16'(be_merge(64'(cfg_q.host_udp_port), wd, be));
            W_FPGA_MAC:      cfg_d.fpga_mac = 48'(be_merge(64'(cfg_q.fpga_mac), wd, be));
            W_HOST_MAC:      cfg_d.host_mac = 48'(be_merge(64'(cfg_q.host_mac), wd, be));
            W_FPGA_IP:       cfg_d.fpga_ip = 32'(be_merge(64'(cfg_q.fpga_ip), wd, be));
            W_HOST_IP:       cfg_d.host_ip = 32'(be_merge(64'(cfg_q.host_ip), wd, be));
            W_NETMASK:       cfg_d.netmask = 32'(be_merge(64'(cfg_q.netmask), wd, be));
            W_PAYLOAD:       cfg_d.payload_per_packet = 16'(be_merge(64'(cfg_q.payload_per_packet), wd, be));
            W_CHECKSUM_IP:   cfg_d.checksum_ip = 16'(be_merge(64'(cfg_q.checksum_ip), wd, be));
            default:         ;
         endcase
      end
      for (int c = 0; c < NUM_CHAN; c++) begin
         if (avmm.avmm_write && ch_sel[c] && (ch_sub == CH_MISC))
            misc_d[c] = be_merge(misc_q[c], wd, be);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scratch_q  <= 64'd0;
         cfg_q      <= '0;
         misc_q     <= '0;
         readdata_q <= 64'd0;
         rdvalid_q  <= 1'b0;
      end else begin
         scratch_q <= scratch_d;
         cfg_q     <= cfg_d;
         misc_q    <= misc_d;
         rdvalid_q <= avmm.avmm_read;
         if (avmm.avmm_read) readdata_q <= rd_data;
      end
   end

   assign cfg                     = cfg_q;
   assign chan_misc_ctrl          = misc_q;
   assign avmm.avmm_readdata      = readdata_q;
   assign avmm.avmm_readdatavalid = rdvalid_q;
   assign avmm.avmm_waitrequest   = 1'b0;

endmodule

// File: tb/tb_udp_oe_csr_multich.sv
// Directed self-checking bench for udp_oe_csr_multich (2 channels, 20-cycle pulses).
module tb_udp_oe_csr_multich;
   import udp_oe_pkg::*;

   localparam int NUM_CHAN = 2;
   localparam int PULSE    = 20;

   logic clk = 1'b0;
   logic reset;
   udp_oe_csr_multich_if avmm_if ();
   udp_oe_cfg_t               cfg;
   logic [NUM_CHAN-1:0]       chan_tx_rst, chan_rx_rst;
   logic [NUM_CHAN-1:0][63:0] chan_misc_ctrl;
   logic [NUM_CHAN-1:0][31:0] chan_tx_status, chan_rx_status;
   logic [NUM_CHAN-1:0]       chan_tx_pkt, chan_rx_pkt;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   udp_oe_csr_multich #(
      .NUM_CHAN         (NUM_CHAN),
      .CHAN_BASE        ('h20),
      .RST_PULSE_CYCLES (PULSE)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .avmm           (avmm_if),
      .cfg            (cfg),
      .chan_tx_rst    (chan_tx_rst),
      .chan_rx_rst    (chan_rx_rst),
      .chan_misc_ctrl (chan_misc_ctrl),
      .chan_tx_status (chan_tx_status),
      .chan_rx_status (chan_rx_status),
      .chan_tx_pkt    (chan_tx_pkt),
      .chan_rx_pkt    (chan_rx_pkt)
   );

   task automatic bus_write(input logic [11:0] a, input logic [63:0] d, input logic [7:0] b);
      @(posedge clk); #1;
      avmm_if.avmm_write = 1'b1; avmm_if.avmm_address = a;
      avmm_if.avmm_writedata = d; avmm_if.avmm_byteenable = b;
      @(posedge clk); #1;
      avmm_if.avmm_write = 1'b0;
   endtask

   task automatic bus_read(input logic [11:0] a, output logic [63:0] d, output logic v);
      @(posedge clk); #1;
      avmm_if.avmm_read = 1'b1; avmm_if.avmm_address = a;
      @(posedge clk); #1;
      avmm_if.avmm_read = 1'b0;
      d = avmm_if.avmm_readdata;
      v = avmm_if.avmm_readdatavalid;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (avmm_if.avmm_readdatavalid !== 1'b0 || avmm_if.avmm_readdata !== 64'd0 ||
          avmm_if.avmm_waitrequest !== 1'b0)
         $display("FAIL reset_bus: got rdv=%b rd=%h wr=%b expected 0/0/0",
                  avmm_if.avmm_readdatavalid, avmm_if.avmm_readdata, avmm_if.avmm_waitrequest);
      else passed++;
      checks++;
      if (cfg !== '0 || chan_misc_ctrl !== '0 || chan_tx_rst !== '0 || chan_rx_rst !== '0)
         $display("FAIL reset_outputs: got cfg=%h misc=%h tx=%b rx=%b expected all 0",
                  cfg, chan_misc_ctrl, chan_tx_rst, chan_rx_rst);
      else passed++;
      reset = 1'b0;
   endtask

   task automatic test_common_map();
      logic [63:0] d; logic v;
      bus_read(12'h030, d, v);
      checks++;
      if (v !== 1'b1 || d !== 64'd2) $display("FAIL num_chan: got v=%b %h expected 1 %h", v, d, 64'd2);
      else passed++;
      bus_read(12'h000, d, v);
      checks++;
      if (d !== 64'h3000_0001_0000_1001) $display("FAIL dfh_header: got %h expected %h", d, 64'h3000_0001_0000_1001);
      else passed++;
      bus_read(12'h080, d, v);
      checks++;
      if (d !== REG_RD_BADADDR_DATA) $display("FAIL common_hole: got %h expected %h", d, REG_RD_BADADDR_DATA);
      else passed++;
   endtask

   task automatic test_scratchpad();
      logic [63:0] d; logic v;
      bus_write(12'h028, 64'hDEAD_BEEF_0123_4567, 8'hFF);
      bus_read(12'h028, d, v);
      checks++;
      if (v !== 1'b1 || d !== 64'hDEAD_BEEF_0123_4567)
         $display("FAIL scratch_rd: got v=%b %h expected 1 %h", v, d, 64'hDEAD_BEEF_0123_4567);
      else passed++;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (avmm_if.avmm_readdatavalid !== 1'b0 || avmm_if.avmm_readdata !== 64'hDEAD_BEEF_0123_4567)
         $display("FAIL rd_hold: got v=%b %h expected 0 %h", avmm_if.avmm_readdatavalid,
                  avmm_if.avmm_readdata, 64'hDEAD_BEEF_0123_4567);
      else passed++;
   endtask

   task automatic test_cfg_byteenable();
      logic [63:0] d; logic v;
      bus_write(12'h038, 64'h1234, 8'hFF);
      bus_write(12'h038, 64'hFF, 8'h01);
      checks++;
      if (cfg.fpga_udp_port !== 16'h12FF) $display("FAIL cfg_be_port: got %h expected %h", cfg.fpga_udp_port, 16'h12FF);
      else passed++;
      bus_read(12'h038, d, v);
      checks++;
      if (d !== 64'h12FF) $display("FAIL cfg_be_rd: got %h expected %h", d, 64'h12FF);
      else passed++;
      bus_write(12'h048, 64'hFFFF_A1B2_C3D4_E5F6, 8'hFF);
      bus_read(12'h048, d, v);
      checks++;
      if (d !== 64'h0000_A1B2_C3D4_E5F6 || cfg.fpga_mac !== 48'hA1B2_C3D4_E5F6)
         $display("FAIL cfg_mac_trunc: got %h/%h expected %h", d, cfg.fpga_mac, 64'h0000_A1B2_C3D4_E5F6);
      else passed++;
   endtask

   task automatic test_chan_map();
      logic [63:0] d; logic v;
      bus_read(12'h100, d, v);
      checks++;
      if (d !== 64'h10) $display("FAIL ch0_info: got %h expected %h", d, 64'h10);
      else passed++;
      bus_read(12'h180, d, v);
      checks++;
      if (d !== 64'h1_0110) $display("FAIL ch1_info: got %h expected %h", d, 64'h1_0110);
      else passed++;
      bus_read(12'h200, d, v);
      checks++;
      if (d !== REG_RD_BADADDR_DATA) $display("FAIL ch2_info: got %h expected %h", d, REG_RD_BADADDR_DATA);
      else passed++;
      bus_read(12'h130, d, v);
      checks++;
      if (d !== REG_RD_BADADDR_DATA) $display("FAIL ch0_off6: got %h expected %h", d, REG_RD_BADADDR_DATA);
      else passed++;
      chan_tx_status[1] = 32'hAAAA_5555;
      chan_rx_status[1] = 32'h1234_5678;
      bus_read(12'h190, d, v);
      checks++;
      if (d !== 64'hAAAA_5555_1234_5678) $display("FAIL ch1_status: got %h expected %h", d, 64'hAAAA_5555_1234_5678);
      else passed++;
   endtask

   task automatic test_misc();
      logic [63:0] d; logic v;
      bus_write(12'h118, 64'h1111_2222_3333_4444, 8'hFF);
      bus_write(12'h118, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0);
      bus_write(12'h218, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      bus_read(12'h118, d, v);
      checks++;
      if (d !== 64'hAAAA_BBBB_3333_4444 || chan_misc_ctrl[0] !== 64'hAAAA_BBBB_3333_4444)
         $display("FAIL ch0_misc: got %h/%h expected %h", d, chan_misc_ctrl[0], 64'hAAAA_BBBB_3333_4444);
      else passed++;
      checks++;
      if (chan_misc_ctrl[1] !== 64'd0) $display("FAIL badaddr_wr: got %h expected %h", chan_misc_ctrl[1], 64'd0);
      else passed++;
   endtask

   task automatic test_rst_pulse();
      logic [63:0] d; logic v; int n; logic split;
      bus_write(12'h108, 64'h13, 8'hFF);
      n = 0; split = 1'b0;
      while (chan_tx_rst[0] === 1'b1 && n < 300) begin
         if (chan_rx_rst[0] !== 1'b1) split = 1'b1;
         n++;
         @(posedge clk); #1;
      end
      checks++;
      if (n != PULSE || split) $display("FAIL pulse_len: got %0d split=%b expected %0d", n, split, PULSE);
      else passed++;
      checks++;
      if (chan_tx_rst[0] !== 1'b0 || chan_rx_rst[0] !== 1'b0)
         $display("FAIL pulse_end: got tx=%b rx=%b expected 0 0", chan_tx_rst[0], chan_rx_rst[0]);
      else passed++;
      bus_write(12'h108, 64'h13, 8'hFF);
      bus_read(12'h108, d, v);
      checks++;
      if (d !== 64'h13) $display("FAIL pulse_busy: got %h expected %h", d, 64'h13);
      else passed++;
      repeat (5) @(posedge clk);
      bus_write(12'h108, 64'h12, 8'hFF);
      n = 0;
      while (chan_tx_rst[0] === 1'b1 && n < 300) begin
         n++;
         @(posedge clk); #1;
      end
      checks++;
      if (n != PULSE) $display("FAIL pulse_restart: got %0d expected %0d", n, PULSE);
      else passed++;
      bus_read(12'h108, d, v);
      checks++;
      if (d !== 64'd0) $display("FAIL pulse_idle_rd: got %h expected %h", d, 64'd0);
      else passed++;
   endtask

   task automatic test_held();
      logic [63:0] d; logic v;
      bus_write(12'h188, 64'h02, 8'hFF);
      repeat (PULSE + 5) @(posedge clk);
      #1;
      checks++;
      if (chan_tx_rst[1] !== 1'b1 || chan_rx_rst[1] !== 1'b0)
         $display("FAIL held_lvl: got tx=%b rx=%b expected 1 0", chan_tx_rst[1], chan_rx_rst[1]);
      else passed++;
      bus_read(12'h188, d, v);
      checks++;
      if (d !== 64'h02) $display("FAIL held_rd: got %h expected %h", d, 64'h02);
      else passed++;
      bus_write(12'h188, 64'h00, 8'hFF);
      checks++;
      if (chan_tx_rst[1] !== 1'b0) $display("FAIL held_clear: got %b expected 0", chan_tx_rst[1]);
      else passed++;
   endtask

   task automatic test_pkt_count();
      logic [63:0] d; logic v;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1; chan_rx_pkt[1] = 1'b1;
         @(posedge clk); #1; chan_rx_pkt[1] = 1'b0;
      end
      bus_read(12'h1A8, d, v);
`ifdef UDP_OE_CSR_PKT_CNT_EN
      checks++;
      if (d !== 64'd10) $display("FAIL rx_cnt10: got %h expected %h", d, 64'd10);
      else passed++;
`else
      checks++;
      if (d !== 64'd0) $display("FAIL rx_cnt_off: got %h expected %h", d, 64'd0);
      else passed++;
`endif
      bus_read(12'h1A0, d, v);
      checks++;
      if (d !== 64'd0) $display("FAIL tx_cnt_zero: got %h expected %h", d, 64'd0);
      else passed++;
      @(posedge clk); #1;
      avmm_if.avmm_write = 1'b1; avmm_if.avmm_address = 12'h1A8;
      avmm_if.avmm_writedata = 64'd0; avmm_if.avmm_byteenable = 8'hFF;
      chan_rx_pkt[1] = 1'b1;
      @(posedge clk); #1;
      avmm_if.avmm_write = 1'b0; chan_rx_pkt[1] = 1'b0;
      bus_read(12'h1A8, d, v);
`ifdef UDP_OE_CSR_PKT_CNT_EN
      checks++;
      if (d !== 64'd1) $display("FAIL clr_inc: got %h expected %h", d, 64'd1);
      else passed++;
`else
      checks++;
      if (d !== 64'd0) $display("FAIL clr_inc_off: got %h expected %h", d, 64'd0);
      else passed++;
`endif
   endtask

   task automatic test_rd_wr_same();
      logic [63:0] d; logic v;
      @(posedge clk); #1;
      avmm_if.avmm_read = 1'b1; avmm_if.avmm_write = 1'b1; avmm_if.avmm_address = 12'h028;
      avmm_if.avmm_writedata = 64'h0F0F_0F0F_A5A5_A5A5; avmm_if.avmm_byteenable = 8'hFF;
      @(posedge clk); #1;
      avmm_if.avmm_read = 1'b0; avmm_if.avmm_write = 1'b0;
      checks++;
      if (avmm_if.avmm_readdata !== 64'hDEAD_BEEF_0123_4567)
         $display("FAIL rw_pre: got %h expected %h", avmm_if.avmm_readdata, 64'hDEAD_BEEF_0123_4567);
      else passed++;
      bus_read(12'h028, d, v);
      checks++;
      if (d !== 64'h0F0F_0F0F_A5A5_A5A5) $display("FAIL rw_post: got %h expected %h", d, 64'h0F0F_0F0F_A5A5_A5A5);
      else passed++;
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      avmm_if.avmm_read = 1'b1; avmm_if.avmm_address = 12'h030;
      @(posedge clk); #1;
      avmm_if.avmm_address = 12'h180;
      checks++;
      if (avmm_if.avmm_readdatavalid !== 1'b1 || avmm_if.avmm_readdata !== 64'd2)
         $display("FAIL b2b_first: got v=%b %h expected 1 %h", avmm_if.avmm_readdatavalid, avmm_if.avmm_readdata, 64'd2);
      else passed++;
      @(posedge clk); #1;
      avmm_if.avmm_read = 1'b0;
      checks++;
      if (avmm_if.avmm_readdatavalid !== 1'b1 || avmm_if.avmm_readdata !== 64'h1_0110)
         $display("FAIL b2b_second: got v=%b %h expected 1 %h", avmm_if.avmm_readdatavalid, avmm_if.avmm_readdata, 64'h1_0110);
      else passed++;
   endtask

   task automatic test_reset_mid_pulse();
      logic [63:0] d; logic v;
      bus_write(12'h108, 64'h13, 8'hFF);
      repeat (5) @(posedge clk);
      #3; reset = 1'b1;
      #1;
      checks++;
      if (chan_tx_rst[0] !== 1'b0 || chan_rx_rst[0] !== 1'b0 || avmm_if.avmm_readdata !== 64'd0)
         $display("FAIL async_abort: got tx=%b rx=%b rd=%h expected 0 0 0",
                  chan_tx_rst[0], chan_rx_rst[0], avmm_if.avmm_readdata);
      else passed++;
      avmm_if.avmm_read = 1'b1; avmm_if.avmm_address = 12'h028;
      @(posedge clk); #1;
      avmm_if.avmm_read = 1'b0;
      checks++;
      if (avmm_if.avmm_readdatavalid !== 1'b0) $display("FAIL rd_in_reset: got %b expected 0", avmm_if.avmm_readdatavalid);
      else passed++;
      reset = 1'b0;
      bus_read(12'h028, d, v);
      checks++;
      if (d !== 64'd0) $display("FAIL post_rst_scratch: got %h expected %h", d, 64'd0);
      else passed++;
      bus_read(12'h108, d, v);
      checks++;
      if (d !== 64'd0 || chan_tx_rst[0] !== 1'b0) $display("FAIL post_rst_ctrl: got %h tx=%b expected 0", d, chan_tx_rst[0]);
      else passed++;
      bus_read(12'h038, d, v);
      checks++;
      if (d !== 64'd0 || chan_misc_ctrl !== '0) $display("FAIL post_rst_cfg: got %h misc=%h expected 0", d, chan_misc_ctrl);
      else passed++;
   endtask

   initial begin
      reset = 1'b1;
      avmm_if.avmm_address = 12'd0; avmm_if.avmm_read = 1'b0; avmm_if.avmm_write = 1'b0;
      avmm_if.avmm_writedata = 64'd0; avmm_if.avmm_byteenable = 8'd0;
      chan_tx_status = '0; chan_rx_status = '0; chan_tx_pkt = '0; chan_rx_pkt = '0;
      test_reset();
      test_common_map();
      test_scratchpad();
      test_cfg_byteenable();
      test_chan_map();
      test_misc();
      test_rst_pulse();
      test_held();
      test_pkt_count();
      test_rd_wr_same();
      test_back_to_back();
      test_reset_mid_pulse();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/udp_oe_csr_multich.md
UDP_OE_CSR_MULTICH -- requirements
Module: udp_oe_csr_multich

Interface
REQ-001 SHALL have parameter NUM_CHAN, default 2, number of I/O-pipe channels, legal range 1..16.
REQ-002 SHALL have parameter CHAN_BASE, default 'h20, word address of channel 0 registers.
REQ-003 SHALL have parameter RST_PULSE_CYCLES, default 64, auto-clear reset pulse length, legal range 2..255.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port avmm_address / avmm_read / avmm_write, input, 12/1/1, byte-addressed Avalon-MM CSR slave.
REQ-007 SHALL have port avmm_writedata / avmm_byteenable, input, 64/8, write data and byte lanes.
REQ-008 SHALL have port avmm_readdata / avmm_readdatavalid / avmm_waitrequest, output, 64/1/1, read response.
REQ-009 SHALL have port cfg, output, udp_oe_cfg_t, common fields: fpga/host MAC, IP, UDP port, netmask, payload_per_packet, checksum_ip.
REQ-010 SHALL have port chan_tx_rst / chan_rx_rst, output, NUM_CHAN, per-channel resets.
REQ-011 SHALL have port chan_misc_ctrl, output, NUM_CHAN x 64, per-channel misc control.
REQ-012 SHALL have port chan_tx_status / chan_rx_status, input, NUM_CHAN x 32, per-channel status.
REQ-013 SHALL have port chan_tx_pkt / chan_rx_pkt, input, NUM_CHAN, one-cycle packet-done pulses.

Function
REQ-014 Word address SHALL be avmm_address>>3; avmm_waitrequest SHALL be constant 0.
REQ-015 Read SHALL return readdatavalid and readdata exactly 1 cycle after avmm_read; readdata holds until next read.
REQ-016 Common map (words): 0x00-0x04 DFH header/ID_LO/ID_HI/reg-offset/regsz-params; 0x05 scratchpad RW; 0x06 NUM_CHAN RO; 0x07-0x0F the nine cfg fields RW, zero-extended on read.
REQ-017 Channel c block SHALL start at CHAN_BASE+16*c: +0 info RO {47'b0, eol=(c==NUM_CHAN-1), 8'(c), 8'h10}; +1 reset ctrl; +2 status RO {tx_status,rx_status}; +3 misc_ctrl RW; +4 tx packet count; +5 rx packet count.
REQ-018 Any other word, incl. offsets +6..+15 and channels >= NUM_CHAN, SHALL read REG_RD_BADADDR_DATA; writes there SHALL be ignored.
REQ-019 Writes SHALL honour avmm_byteenable per byte lane; cfg fields ignore bits above their width.
REQ-020 Simultaneous read and write to the same word SHALL return the pre-write value.
REQ-021 Reset ctrl write: bit0 rx_rst, bit1 tx_rst, bit4 AUTO; read returns {59'b0, busy, 2'b0, tx_rst, rx_rst}, busy=bit4.
REQ-022 Per-channel FSM IDLE/HELD/PULSE: write with AUTO=0 SHALL load bits into HELD (IDLE if both 0); AUTO=1 with any bit set SHALL enter PULSE and load a counter with RST_PULSE_CYCLES.
REQ-023 In PULSE the selected resets SHALL stay asserted exactly RST_PULSE_CYCLES cycles then clear together, FSM to IDLE; a write during PULSE SHALL restart per REQ-022.
REQ-024 Packet counters SHALL be 32-bit, saturate at 'hFFFF_FFFF, and clear on any write to their word.
REQ-025 Clear and increment in the same cycle SHALL yield count 1.

Reset
REQ-026 On reset all outputs, cfg, scratchpad, misc_ctrl, resets, counters, readdata SHALL be 0; readdatavalid 0; FSMs IDLE.
REQ-027 Reset mid-PULSE SHALL abort the pulse; no read response for a read in the reset cycle.

Configuration
REQ-028 With UDP_OE_CSR_PKT_CNT_EN defined, counters per REQ-024/025 exist; without it offsets +4/+5 read 0, writes ignored, chan_*_pkt unused.

Structure
REQ-029 udp_oe_pkg SHALL hold udp_oe_cfg_t, common word addresses, channel offsets, DFH constants, REG_RD_BADADDR_DATA.
REQ-030 Per-channel reset FSM plus counters SHALL be sub-module udp_oe_csr_chan, generated NUM_CHAN times.

Verification
REQ-031 Write 'hDEAD_BEEF_0123_4567 to 0x28 (scratchpad), read -> same value 1 cycle later.
REQ-032 NUM_CHAN=2, read byte 0x180 (ch1 +0) -> 'h1_0110; read ch2 +0 -> REG_RD_BADADDR_DATA.
REQ-033 Write 'h13 to ch0 +1 -> tx/rx_rst high exactly RST_PULSE_CYCLES, busy reads 1 meanwhile, then all 0.
REQ-034 Write 'hFF to 0x38 with byteenable 'h01 over 'h1234 -> fpga_udp_port 'h12FF.
REQ-035 10 chan_rx_pkt pulses on ch1 -> ch1 +5 reads 10; write + pulse same cycle -> reads 1.
REQ-036 Assert reset mid-PULSE -> resets drop asynchronously, all registers read 0 after release.
